// File: rtl/rdma_rc_mq_buf_pkg.sv
// Shared widths, helper function and types for the per-QP frame-aware buffer.
package rdma_rc_mq_buf_pkg;

  localparam int DATA_WIDTH_DEF = 64;
  localparam int NUM_CH_DEF     = 4;
  localparam int CH_DEPTH_DEF   = 16;

  function automatic int clog2(input int n);
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) >= n) return i;
    end
    return 32;
  endfunction

  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0] data;
    logic                      last;
  } beat_t;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rdma_rc_mq_buf_if.sv
// AXI-Stream style bus with channel routing (tdest) used for ingress and egress.
interface rdma_rc_mq_buf_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CH_W       = 2
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [CH_W-1:0]       tdest;

  modport master (output tdata, tvalid, tlast, tdest, input tready);
  modport slave  (input tdata, tvalid, tlast, tdest, output tready);
endinterface

// File: rtl/rdma_rc_mq_buf_ch_fifo.sv
// Single-channel synchronous FIFO with show-ahead read data and occupancy count.
module rdma_rc_ch_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             wr_en;
  logic             rd_en;

  assign wr_en = wr & ~full;
  assign rd_en = rd & ~empty;

  // Storage is not reset; clearing the pointers discards any stored beats.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/rdma_rc_mq_buf.sv
// Multi-channel frame-aware buffer: per-QP FIFOs, frame-atomic round-robin egress.
// Define RDMA_BUF_SAF_EN for store-and-forward (only complete frames start on egress).
module rdma_rc_mq_buf
  import rdma_rc_mq_buf_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int CH_DEPTH   = CH_DEPTH_DEF,
  parameter int CH_W       = clog2(NUM_CH),
  parameter int AW         = clog2(CH_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        send_pause,
  rdma_rc_mq_buf_if.slave          s_axis,
  rdma_rc_mq_buf_if.master         m_axis,
  output logic [NUM_CH-1:0]        buf_full,
  output logic [NUM_CH-1:0]        buf_empty,
  output logic [NUM_CH*(AW+1)-1:0] buf_level,
  output logic                     backpressure
);

  // Arbiter states
  //   state      | meaning
  //   ARB_OPEN   | between frames; round-robin over unpaused channels
  //   ARB_LOCKED | frame in flight on lock_ch; only lock_ch may send until tlast

  localparam int BW = DATA_WIDTH + 1;

  logic                  dest_ok;
  logic                  accept;
  logic [NUM_CH-1:0]     wr_vec;
  logic [NUM_CH-1:0]     rd_vec;
  logic [NUM_CH-1:0]     full_v;
  logic [NUM_CH-1:0]     empty_v;
  logic [NUM_CH-1:0]     saf_ok;
  logic [NUM_CH-1:0]     elig;
  logic [AW:0]           count_v [NUM_CH];
  logic [BW-1:0]         rdata_v [NUM_CH];

  arb_state_t            state;
  arb_state_t            state_nxt;
  logic [CH_W-1:0]       lock_ch;
  logic [CH_W-1:0]       lock_ch_nxt;
  logic [CH_W-1:0]       last_grant;
  logic [CH_W-1:0]       gnt_ch;
  logic                  grant;
  logic                  load_en;

  logic [DATA_WIDTH-1:0] m_data_r;
  logic                  m_valid_r;
  logic                  m_last_r;
  logic [CH_W-1:0]       m_dest_r;

  assign dest_ok       = int'(s_axis.tdest) < NUM_CH;
  assign s_axis.tready = dest_ok ? ~full_v[s_axis.tdest] : 1'b1;
  assign accept        = s_axis.tvalid & s_axis.tready & dest_ok;

  always_comb begin
    wr_vec = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_vec[c] = accept & (s_axis.tdest == CH_W'(c));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    rdma_rc_ch_fifo #(
      .WIDTH (BW),
      .DEPTH (CH_DEPTH),
      .AW    (AW)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .wr    (wr_vec[g]),
      .wdata ({s_axis.tlast, s_axis.tdata}),
      .rd    (rd_vec[g]),
      .rdata (rdata_v[g]),
      .full  (full_v[g]),
      .empty (empty_v[g]),
      .count (count_v[g])
    );
    assign buf_level[g*(AW+1) +: AW+1] = count_v[g];
  end

`ifdef RDMA_BUF_SAF_EN
  logic [AW:0] frame_cnt [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) frame_cnt[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        case ({wr_vec[c] & s_axis.tlast, rd_vec[c] & rdata_v[c][BW-1]})
          2'b10:   frame_cnt[c] <= frame_cnt[c] + 1'b1;
          2'b01:   frame_cnt[c] <= frame_cnt[c] - 1'b1;
          default: frame_cnt[c] <= frame_cnt[c];
        endcase
      end
    end
  end

  // A full channel may start anyway, otherwise frames longer than the FIFO would deadlock.
  always_comb begin
    saf_ok = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      saf_ok[c] = (frame_cnt[c] != '0) | full_v[c];
    end
  end
`else
  assign saf_ok = '1;
`endif

  always_comb begin
    elig = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (state == ARB_LOCKED) elig[c] = ~empty_v[c] & (lock_ch == CH_W'(c));
      else                     elig[c] = ~empty_v[c] & ~send_pause[c] & saf_ok[c];
    end
  end

  always_comb begin
    int idx;
    idx         = 0;
    load_en     = ~m_valid_r | m_axis.tready;
    grant       = 1'b0;
    gnt_ch      = '0;
    rd_vec      = '0;
    state_nxt   = state;
    lock_ch_nxt = lock_ch;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(last_grant) + i) % NUM_CH;
      if (!grant && elig[idx]) begin
        grant  = 1'b1;
        gnt_ch = CH_W'(idx);
      end
    end
    grant = grant & load_en;
    if (grant) begin
      rd_vec[gnt_ch] = 1'b1;
      if (rdata_v[gnt_ch][BW-1]) begin
        state_nxt = ARB_OPEN;
      end else begin
        state_nxt   = ARB_LOCKED;
        lock_ch_nxt = gnt_ch;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_OPEN;
      lock_ch    <= '0;
      last_grant <= '0;
    end else begin
      state   <= state_nxt;
      lock_ch <= lock_ch_nxt;
      if (grant) last_grant <= gnt_ch;
    end
  end

  // Data/dest hold when nothing is granted; only valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data_r  <= '0;
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
      m_dest_r  <= '0;
    end else if (load_en) begin
      if (grant) begin
        {m_last_r, m_data_r} <= rdata_v[gnt_ch];
        m_dest_r             <= gnt_ch;
        m_valid_r            <= 1'b1;
      end else begin
        m_valid_r <= 1'b0;
      end
    end
  end

  assign m_axis.tdata  = m_data_r;
  assign m_axis.tvalid = m_valid_r;
  assign m_axis.tlast  = m_last_r;
  assign m_axis.tdest  = m_dest_r;

  assign buf_full     = full_v;
  assign buf_empty    = empty_v;
  assign backpressure = |full_v;

endmodule

// File: tb/tb_rdma_rc_mq_buf.sv
// Directed self-checking bench for rdma_rc_mq_buf (4 channels, depth 16).
module tb_rdma_rc_mq_buf;

  localparam int DW    = 64;
  localparam int NC    = 4;
  localparam int DEPTH = 16;
  localparam int CW    = 2;
  localparam int AW    = 4;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NC-1:0]           send_pause;
  logic [NC-1:0]           buf_full;
  logic [NC-1:0]           buf_empty;
  logic [NC*(AW+1)-1:0]    buf_level;
  logic                    backpressure;
  int                      checks = 0;
  int                      failures = 0;

  rdma_rc_mq_buf_if #(.DATA_WIDTH(DW), .CH_W(CW)) s_if ();
  rdma_rc_mq_buf_if #(.DATA_WIDTH(DW), .CH_W(CW)) m_if ();

  always #5 clk = ~clk;

  rdma_rc_mq_buf #(
    .DATA_WIDTH (DW),
    .NUM_CH     (NC),
    .CH_DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .send_pause   (send_pause),
    .s_axis       (s_if.slave),
    .m_axis       (m_if.master),
    .buf_full     (buf_full),
    .buf_empty    (buf_empty),
    .buf_level    (buf_level),
    .backpressure (backpressure)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input logic [63:0] data, input logic last);
    s_if.tvalid = 1'b1;
    s_if.tdest  = CW'(ch);
    s_if.tdata  = data;
    s_if.tlast  = last;
    step();
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  function automatic logic [AW:0] lvl(input int ch);
    return buf_level[ch*(AW+1) +: AW+1];
  endfunction

  task automatic chk_beat(input string tag, input logic [63:0] data, input int dest, input logic last);
    chk({tag, "_valid"}, 64'(m_if.tvalid), 64'd1);
    chk({tag, "_data"}, m_if.tdata, data);
    chk({tag, "_dest"}, 64'(m_if.tdest), 64'(dest));
    chk({tag, "_last"}, 64'(m_if.tlast), 64'(last));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp_d;
    int          idx;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    s_if.tdest  = '0;
    m_if.tready = 1'b0;
    send_pause  = '0;
    step();
    step();
    chk("rst_valid", 64'(m_if.tvalid), 64'd0);
    chk("rst_data", m_if.tdata, 64'd0);
    chk("rst_empty", 64'(buf_empty), 64'hF);
    chk("rst_full", 64'(buf_full), 64'h0);
    chk("rst_level", 64'(buf_level), 64'h0);
    chk("rst_bp", 64'(backpressure), 64'd0);
    chk("rst_tready", 64'(s_if.tready), 64'd1);
    rst_n = 1'b1;
    step();

`ifndef RDMA_BUF_SAF_EN
    // 1: three-beat frame on ch2, cut-through
    m_if.tready = 1'b1;
    push(2, 64'hA0, 1'b0);
    chk("t1_lat_valid", 64'(m_if.tvalid), 64'd0);
    chk("t1_lvl", 64'(lvl(2)), 64'd1);
    push(2, 64'hA1, 1'b0);
    chk_beat("t1_a0", 64'hA0, 2, 1'b0);
    push(2, 64'hA2, 1'b1);
    chk_beat("t1_a1", 64'hA1, 2, 1'b0);
    step();
    chk_beat("t1_a2", 64'hA2, 2, 1'b1);
    step();
    chk("t1_idle", 64'(m_if.tvalid), 64'd0);
    chk("t1_empty", 64'(buf_empty), 64'hF);

    // 2: fill ch0, blocked egress
    do_reset();
    m_if.tready = 1'b0;
    for (int k = 0; k < 16; k++) push(0, 64'h200 + 64'(k), 1'b0);
    chk("t2_lvl15", 64'(lvl(0)), 64'd15);
    chk("t2_notfull", 64'(buf_full[0]), 64'd0);
    chk_beat("t2_head", 64'h200, 0, 1'b0);
    push(0, 64'h210, 1'b0);
    chk("t2_full", 64'(buf_full), 64'h1);
    chk("t2_lvl16", 64'(lvl(0)), 64'd16);
    chk("t2_bp", 64'(backpressure), 64'd1);
    s_if.tvalid = 1'b1;
    s_if.tdest  = 2'd0;
    s_if.tdata  = 64'hDEAD;
    #1;
    chk("t2_tready0", 64'(s_if.tready), 64'd0);
    step();
    chk("t2_nooverflow", 64'(lvl(0)), 64'd16);
    s_if.tdest = 2'd1;
    s_if.tdata = 64'h111;
    #1;
    chk("t2_tready1", 64'(s_if.tready), 64'd1);
    step();
    s_if.tvalid = 1'b0;
    chk("t2_ch1_lvl", 64'(lvl(1)), 64'd1);
    chk("t2_held", m_if.tdata, 64'h200);
    m_if.tready = 1'b1;
    s_if.tvalid = 1'b1;
    s_if.tdest  = 2'd0;
    #1;
    chk("t2_fullrw_tready", 64'(s_if.tready), 64'd0);
    step();
    s_if.tvalid = 1'b0;
    chk("t2_fullrw_lvl", 64'(lvl(0)), 64'd15);
    chk("t2_fullrw_data", m_if.tdata, 64'h201);
    m_if.tready = 1'b0;

    // 3: two-beat frames on ch0, ch1, ch3 drain in order
    do_reset();
    m_if.tready = 1'b0;
    push(0, 64'h300, 1'b0);
    push(0, 64'h301, 1'b1);
    push(1, 64'h310, 1'b0);
    push(1, 64'h311, 1'b1);
    push(3, 64'h330, 1'b0);
    push(3, 64'h331, 1'b1);
    m_if.tready = 1'b1;
    chk_beat("t3_b0", 64'h300, 0, 1'b0);
    step();
    chk_beat("t3_b1", 64'h301, 0, 1'b1);
    step();
    chk_beat("t3_b2", 64'h310, 1, 1'b0);
    step();
    chk_beat("t3_b3", 64'h311, 1, 1'b1);
    step();
    chk_beat("t3_b4", 64'h330, 3, 1'b0);
    step();
    chk_beat("t3_b5", 64'h331, 3, 1'b1);
    step();
    chk("t3_idle", 64'(m_if.tvalid), 64'd0);

    // 4: pause mid-frame only blocks the next frame
    do_reset();
    m_if.tready = 1'b1;
    push(1, 64'h400, 1'b0);
    push(1, 64'h401, 1'b0);
    chk_beat("t4_b0", 64'h400, 1, 1'b0);
    send_pause[1] = 1'b1;
    push(1, 64'h402, 1'b0);
    chk_beat("t4_b1", 64'h401, 1, 1'b0);
    push(1, 64'h403, 1'b1);
    chk_beat("t4_b2", 64'h402, 1, 1'b0);
    push(1, 64'h410, 1'b1);
    chk_beat("t4_b3", 64'h403, 1, 1'b1);
    step();
    chk("t4_paused", 64'(m_if.tvalid), 64'd0);
    chk("t4_pend", 64'(lvl(1)), 64'd1);
    step();
    chk("t4_paused2", 64'(m_if.tvalid), 64'd0);
    send_pause[1] = 1'b0;
    step();
    chk_beat("t4_resume", 64'h410, 1, 1'b1);

    // 5: tready 1010 pattern during a frame
    do_reset();
    m_if.tready = 1'b0;
    push(3, 64'h500, 1'b0);
    push(3, 64'h501, 1'b0);
    push(3, 64'h502, 1'b0);
    push(3, 64'h503, 1'b1);
    chk_beat("t5_head", 64'h500, 3, 1'b0);
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      m_if.tready = (i % 2 == 0);
      step();
      if (i % 2 == 0) idx++;
      exp_d = 64'h500 + 64'(idx);
      chk_beat("t5_beat", exp_d, 3, idx == 3);
    end
    m_if.tready = 1'b1;
    step();
    chk("t5_idle", 64'(m_if.tvalid), 64'd0);
    chk("t5_empty", 64'(buf_empty), 64'hF);
`else
    // 6: store-and-forward holds a partial frame
    do_reset();
    m_if.tready = 1'b1;
    push(2, 64'h600, 1'b0);
    push(2, 64'h601, 1'b0);
    chk("t6_hold", 64'(m_if.tvalid), 64'd0);
    step();
    chk("t6_hold2", 64'(m_if.tvalid), 64'd0);
    chk("t6_lvl", 64'(lvl(2)), 64'd2);
    push(2, 64'h602, 1'b1);
    chk("t6_hold3", 64'(m_if.tvalid), 64'd0);
    step();
    chk_beat("t6_b0", 64'h600, 2, 1'b0);
    step();
    chk_beat("t6_b1", 64'h601, 2, 1'b0);
    step();
    chk_beat("t6_b2", 64'h602, 2, 1'b1);
    step();
    chk("t6_idle", 64'(m_if.tvalid), 64'd0);
`endif

    // reset mid-frame discards stored beats
    m_if.tready = 1'b0;
    push(2, 64'h700, 1'b0);
    push(2, 64'h701, 1'b0);
    push(1, 64'h710, 1'b0);
    chk("mid_lvl1", 64'(lvl(1)), 64'd1);
    do_reset();
    chk("mid_empty", 64'(buf_empty), 64'hF);
    chk("mid_level", 64'(buf_level), 64'h0);
    chk("mid_valid", 64'(m_if.tvalid), 64'd0);
    chk("mid_data", m_if.tdata, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
